// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fb_pkg                                                       |
// | Description : Shared types and constants for the frame-buffer scan-out     |
// |               reader: default raster size, SRAM bus widths, FSM states,    |
// |               read-tag layout and the FIFO word packing helper.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fb_pkg;

  localparam int unsigned FB_H_RES = 640;  // default pixels per line
  localparam int unsigned FB_V_RES = 480;  // default lines per frame
  localparam int unsigned SRAM_AW  = 20;   // word address width ([20:1])
  localparam int unsigned SRAM_DW  = 16;   // SRAM word / pixel width
  localparam int unsigned PIX_W    = SRAM_DW + 2;  // {sof, eol, data}

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Travels alongside each outstanding SRAM read until its data is captured.
  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
  } rd_tag_t;

  function automatic logic [PIX_W-1:0] pack_pixel(input logic sof,
                                                  input logic eol,
                                                  input logic [SRAM_DW-1:0] data);
    return {sof, eol, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_fifo                                                    |
// | Description : Synchronous FIFO buffering captured pixels ahead of the      |
// |               valid/ready output. First-word-fall-through read port.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in  1       clock                                              |
// |   rst      in  1       synchronous reset, active-low                      |
// |   push_i   in  1       write din_i this cycle                             |
// |   din_i    in  WIDTH   write data                                          |
// |   pop_i    in  1       consume head entry this cycle                      |
// |   dout_o   out WIDTH   head entry                                          |
// |   empty_o  out 1       no entries held                                    |
// |   count_o  out CW      number of entries held                             |
// +----------------------------------------------------------------------------+
module scan_fifo
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = 4      // power of two, >= 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Upstream credit accounting already prevents overflow; the gating here
  // only keeps the pointers coherent if that contract is ever broken.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fb_scanout_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_scanout_reader                                            |
// | Description : Reads a finished frame out of the frame-buffer SRAM in       |
// |               raster order and streams it as pixels over valid/ready.      |
// |               Never writes the SRAM.                                       |
// | Options     : define SCANOUT_CHECKSUM_EN to add o_checksum, the 16-bit     |
// |               modular sum of all pixels handed off in the current frame.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in  1   clock                                              |
// |   rst          in  1   synchronous reset, active-low                      |
// |   i_start      in  1   pulse: begin a frame scan (ignored unless idle)    |
// |   o_busy       out 1   scan in progress                                   |
// |   o_done       out 1   one-cycle pulse after the last pixel handshake     |
// |   o_sram_addr  out 20  SRAM word address                                  |
// |   i_sram_data  in  16  SRAM read data                                     |
// |   o_sram_oe_n  out 1   SRAM output enable, active-low                     |
// |   o_sram_we_n  out 1   SRAM write enable, held inactive                   |
// |   o_pix_valid  out 1   pixel available                                    |
// |   i_pix_ready  in  1   sink accepts pixel                                 |
// |   o_pix_data   out 16  pixel value                                        |
// |   o_pix_sof    out 1   first pixel of frame                               |
// |   o_pix_eol    out 1   last pixel of a line                               |
// |   o_checksum   out 16  frame checksum (SCANOUT_CHECKSUM_EN only)          |
// +----------------------------------------------------------------------------+
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int unsigned        H_RES      = FB_H_RES,
  parameter int unsigned        V_RES      = FB_V_RES,
  parameter logic [SRAM_AW-1:0] BASE_ADDR  = '0,
  parameter int unsigned        READ_LAT   = 2,   // 1..4
  parameter int unsigned        FIFO_DEPTH = 4    // power of two, >= READ_LAT+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [SRAM_AW-1:0] o_sram_addr,
  input  logic [SRAM_DW-1:0] i_sram_data,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [SRAM_DW-1:0] o_pix_data,
  output logic               o_pix_sof,
  output logic               o_pix_eol
`ifdef SCANOUT_CHECKSUM_EN
  ,
  output logic [SRAM_DW-1:0] o_checksum
`endif
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = 8;
  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

  scan_state_e               state_q, state_d;
  logic [SRAM_AW-1:0]        idx_q;
  logic [SRAM_AW-1:0]        addr_q;
  logic [15:0]               x_q;
  logic [15:0]               y_q;
  rd_tag_t                   bus_tag_q;   // read presented on the SRAM bus now
  rd_tag_t [READ_LAT-1:0]    sr_q;        // reads waiting for their data

  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic [PIX_W-1:0]          fifo_dout;
  logic [PIX_W-1:0]          fifo_din;

  logic                      start_accept;
  logic                      pop;
  logic                      push;
  logic                      issue;
  logic                      last_issue;
  logic                      credit_ok;
  logic                      drained;
  logic [OCC_W-1:0]          in_flight;
  logic [OCC_W-1:0]          occupancy;

  // --------------------------------------------------------------------------
  // Credit / issue logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_flight = OCC_W'(bus_tag_q.vld);
    for (int i = 0; i < int'(READ_LAT); i++) begin
      in_flight = in_flight + OCC_W'(sr_q[i].vld);
    end
  end

  assign start_accept = (state_q == ST_IDLE) && i_start;
  assign pop          = o_pix_valid && i_pix_ready;
  assign push         = sr_q[READ_LAT-1].vld;

  // A pop this cycle frees its slot in time for a read issued now, which is
  // what lets the pipeline sustain one pixel per cycle at the default depth.
  assign occupancy  = OCC_W'(fifo_count) + in_flight - OCC_W'(pop);
  assign credit_ok  = occupancy < OCC_W'(FIFO_DEPTH);
  assign issue      = (state_q == ST_READ) && credit_ok;
  assign last_issue = issue && (x_q == X_LAST) && (y_q == Y_LAST);

  // Nothing outstanding and the FIFO empties at this edge.
  assign drained = (in_flight == '0) && (OCC_W'(fifo_count) == OCC_W'(pop));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start)    state_d = ST_READ;
      ST_READ:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (drained)    state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= BASE_ADDR;
      bus_tag_q <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      bus_tag_q <= '{vld: issue, sof: (idx_q == '0), eol: (x_q == X_LAST)};
      sr_q[0]   <= bus_tag_q;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        sr_q[i] <= sr_q[i-1];
      end

      if (start_accept) begin
        idx_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (issue) begin
        addr_q <= BASE_ADDR + idx_q;
        idx_q  <= idx_q + SRAM_AW'(1);
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer
  // --------------------------------------------------------------------------
  assign fifo_din = pack_pixel(sr_q[READ_LAT-1].sof, sr_q[READ_LAT-1].eol, i_sram_data);

  scan_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_pix_valid = !fifo_empty;
  assign o_pix_sof   = fifo_dout[PIX_W-1];
  assign o_pix_eol   = fifo_dout[PIX_W-2];
  assign o_pix_data  = fifo_dout[SRAM_DW-1:0];

  assign o_busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign o_done      = (state_q == ST_DONE);
  assign o_sram_addr = addr_q;
  assign o_sram_oe_n = !bus_tag_q.vld;
  assign o_sram_we_n = 1'b1;

`ifdef SCANOUT_CHECKSUM_EN
  logic [SRAM_DW-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (start_accept) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + o_pix_data;
    end
  end

  assign o_checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fb_scanout_reader                                         |
// | Description : Self-checking bench for fb_scanout_reader. Two instances:    |
// |               dut0 (READ_LAT 2, depth 4, base 0) and dut1 (READ_LAT 4,     |
// |               depth 8, base 0x100), both 4x2 pixels. A behavioural SRAM    |
// |               and a frame-level scoreboard derive all expected values.     |
// |               Define SCANOUT_CHECKSUM_EN to also check o_checksum.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fb_scanout_reader;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        rst;
  logic        st0, st1, rdy;
  logic [15:0] sd0, sd1;

  logic        busy0, done0, oe0, we0, pv0, sof0, eol0;
  logic        busy1, done1, oe1, we1, pv1, sof1, eol1;
  logic [19:0] addr0, addr1;
  logic [15:0] pd0, pd1;
`ifdef SCANOUT_CHECKSUM_EN
  logic [15:0] cs0, cs1;
`endif

  always #5 clk = ~clk;

  fb_scanout_reader #(.H_RES(H), .V_RES(V), .BASE_ADDR(20'h0), .READ_LAT(2), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .i_start(st0), .o_busy(busy0), .o_done(done0),
    .o_sram_addr(addr0), .i_sram_data(sd0), .o_sram_oe_n(oe0), .o_sram_we_n(we0),
    .o_pix_valid(pv0), .i_pix_ready(rdy), .o_pix_data(pd0), .o_pix_sof(sof0), .o_pix_eol(eol0)
`ifdef SCANOUT_CHECKSUM_EN
    , .o_checksum(cs0)
`endif
  );

  fb_scanout_reader #(.H_RES(H), .V_RES(V), .BASE_ADDR(20'h100), .READ_LAT(4), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .i_start(st1), .o_busy(busy1), .o_done(done1),
    .o_sram_addr(addr1), .i_sram_data(sd1), .o_sram_oe_n(oe1), .o_sram_we_n(we1),
    .o_pix_valid(pv1), .i_pix_ready(rdy), .o_pix_data(pd1), .o_pix_sof(sof1), .o_pix_eol(eol1)
`ifdef SCANOUT_CHECKSUM_EN
    , .o_checksum(cs1)
`endif
  );

  // ---------------------------------------------------------------- model state
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur = 0;          // which instance the scoreboard follows
  int          rmode = 0;        // 0 ready high, 1 one-on/three-off, 2 random
  bit          chk_en = 0;
  logic [15:0] mem_tab [N];
  logic [17:0] exp_q [$];
  int          rd_cnt, hs_cnt;
  bit          busy_exp, pend_start, exp_done_now, exp_done_next, done_seen;
  bit          held, seen_valid, saw_pause;
  logic [17:0] held_val;
  int          start_cyc, first_v_cyc, last_hs_cyc;
  logic [15:0] exp_sum;
  bit          hv [2][5];
  logic [19:0] ha [2][5];

  function automatic logic [19:0] base_of(input int d);
    return (d != 0) ? 20'h100 : 20'h0;
  endfunction

  function automatic int lat_of(input int d);
    return (d != 0) ? 4 : 2;
  endfunction

  // Behavioural SRAM: word at base+i holds mem_tab[i]; anything else is junk.
  function automatic logic [15:0] sram_word(input bit v, input logic [19:0] a, input int d);
    logic [19:0] off;
    off = a - base_of(d);
    if (v && off < 20'(N)) return mem_tab[off];
    return 16'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: update SRAM, account for the previous edge, check this
  // cycle's outputs, drive inputs for the next edge and predict its handshake.
  task automatic step(input bit st, input bit rs);
    logic        v, bz, dn, we, oe;
    logic [17:0] pix, e;
    logic [19:0] ad;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int k = 4; k > 0; k--) begin
        hv[d][k] = hv[d][k-1];
        ha[d][k] = ha[d][k-1];
      end
      hv[d][0] = (d != 0) ? !oe1 : !oe0;
      ha[d][0] = (d != 0) ? addr1 : addr0;
    end
    sd0 = sram_word(hv[0][2], ha[0][2], 0);
    sd1 = sram_word(hv[1][4], ha[1][4], 1);

    exp_done_now  = exp_done_next;
    exp_done_next = 0;
    if (!rst) begin
      exp_q.delete();
      busy_exp = 0; pend_start = 0; exp_done_now = 0; rd_cnt = 0; held = 0;
    end else if (pend_start) begin
      pend_start = 0; busy_exp = 1; rd_cnt = 0; hs_cnt = 0;
      start_cyc = cyc; seen_valid = 0; saw_pause = 0; exp_sum = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        exp_q.push_back({(i == 0), ((i % H) == H - 1), mem_tab[i]});
        exp_sum = exp_sum + mem_tab[i];
      end
    end

    v   = (cur != 0) ? pv1   : pv0;
    bz  = (cur != 0) ? busy1 : busy0;
    dn  = (cur != 0) ? done1 : done0;
    we  = (cur != 0) ? we1   : we0;
    oe  = (cur != 0) ? oe1   : oe0;
    ad  = (cur != 0) ? addr1 : addr0;
    pix = (cur != 0) ? {sof1, eol1, pd1} : {sof0, eol0, pd0};

    if (chk_en) begin
      chk("we_n", 32'(we), 32'd1);
      chk("busy", 32'(bz), 32'(busy_exp));
      chk("done", 32'(dn), 32'(exp_done_now));
      if (exp_done_now) begin
        done_seen = 1;
        chk("read_total", 32'(rd_cnt), 32'(N));
`ifdef SCANOUT_CHECKSUM_EN
        chk("checksum", 32'((cur != 0) ? cs1 : cs0), 32'(exp_sum));
`endif
      end
      if (held) begin
        chk("stall_valid", 32'(v), 32'd1);
        chk("stall_hold", 32'(pix), 32'(held_val));
      end
      if (!oe) begin
        chk("rd_addr", 32'(ad), 32'(base_of(cur) + 20'(rd_cnt)));
        rd_cnt++;
      end else if (busy_exp && rd_cnt > 0 && rd_cnt < N) begin
        saw_pause = 1;
      end
      if (v && busy_exp && !seen_valid) begin
        seen_valid  = 1;
        first_v_cyc = cyc;
        chk("first_valid_latency", 32'(cyc - start_cyc), 32'(lat_of(cur) + 2));
      end
    end

    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = ((cyc % 4) == 0);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    st0 = (cur == 0) ? st : 1'b0;
    st1 = (cur != 0) ? st : 1'b0;
    rst = rs;
    pend_start = st && rs && !busy_exp && !exp_done_now;

    held = 0;
    if (rs && v && chk_en) begin
      if (rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'(pix), 32'(e));
          hs_cnt++;
          if (exp_q.size() == 0) begin
            exp_done_next = 1;
            busy_exp      = 0;
            last_hs_cyc   = cyc;
          end
        end
      end else begin
        held     = 1;
        held_val = pix;
      end
    end
  endtask

  task automatic run_frame(input int max);
    int n;
    done_seen = 0;
    step(1, 1);
    n = 0;
    while (!done_seen && n < max) begin
      step(0, 1);
      n++;
    end
    chk("frame_timeout", 32'(done_seen), 32'd1);
    step(0, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem_tab[i] = 16'($urandom);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) mem_tab[i] = 16'h1000 + 16'(i);
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int n;
    rst = 1'b0; st0 = 1'b0; st1 = 1'b0; rdy = 1'b0; sd0 = '0; sd1 = '0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 5; k++) begin hv[d][k] = 0; ha[d][k] = '0; end
    fill_ramp();

    // Reset held low for three edges.
    repeat (3) step(0, 0);
    chk_en = 1;
    step(0, 1);
    chk("rst_oe_n", 32'(oe0), 32'd1);
    chk("rst_we_n", 32'(we0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_pix_valid", 32'(pv0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'h0);
    chk("rst_addr_dut1", 32'(addr1), 32'h100);
    chk("rst_pix_valid_dut1", 32'(pv1), 32'd0);

    // Full throughput with ramp data.
    cur = 0; rmode = 0; fill_ramp();
    run_frame(100);
    chk("zero_bubbles", 32'(last_hs_cyc - first_v_cyc), 32'(N - 1));
`ifdef SCANOUT_CHECKSUM_EN
    chk("checksum_ramp", 32'(cs0), 32'h801C);
`endif

    // Backpressure: ready one cycle on, three off.
    rmode = 1;
    run_frame(400);
    chk("oe_pause", 32'(saw_pause), 32'd1);

    // Start while busy, then reset mid-frame, then a clean frame.
    rmode = 2; fill_random();
    step(1, 1);
    n = 0;
    while (hs_cnt < 3 && n < 200) begin step(0, 1); n++; end
    chk("hs3_timeout", 32'(hs_cnt >= 3), 32'd1);
    step(1, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    chk("abort_pix_valid", 32'(pv0), 32'd0);
    chk("abort_oe_n", 32'(oe0), 32'd1);
    chk("abort_addr", 32'(addr0), 32'h0);
    repeat (5) step(0, 1);
    run_frame(400);

    // Longer latency, deeper FIFO, non-zero base.
    cur = 1; rmode = 0; fill_random();
    run_frame(100);
    chk("zero_bubbles_lat4", 32'(last_hs_cyc - first_v_cyc), 32'(N - 1));
    rmode = 2; fill_random();
    run_frame(400);

    // Random data and random ready on the default instance.
    cur = 0;
    repeat (4) begin
      fill_random();
      run_frame(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
